// File: rtl/drive_arbiter_pkg.sv
// Shared motion codes, FSM state codes and per-wheel direction encoding for the drive path.
package drive_arbiter_pkg;

  localparam logic [2:0] CMD_STOP   = 3'd0;
  localparam logic [2:0] CMD_FWD    = 3'd1;
  localparam logic [2:0] CMD_LEFT   = 3'd2;
  localparam logic [2:0] CMD_RIGHT  = 3'd3;
  localparam logic [2:0] CMD_BACK   = 3'd4;
  localparam logic [2:0] CMD_SPIN_L = 3'd5;
  localparam logic [2:0] CMD_SPIN_R = 3'd6;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StDrive = 2'b01,
    StDead  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    DirOff = 2'b00,
    DirFwd = 2'b01,
    DirRev = 2'b10
  } dir_e;

  typedef struct packed {
    dir_e l;
    dir_e r;
  } wheels_t;

  function automatic wheels_t cmd_wheels(input logic [2:0] cmd);
    wheels_t w;
    w.l = DirOff;
    w.r = DirOff;
    case (cmd)
      CMD_FWD:    begin w.l = DirFwd; w.r = DirFwd; end
      CMD_LEFT:   begin w.l = DirOff; w.r = DirFwd; end
      CMD_RIGHT:  begin w.l = DirFwd; w.r = DirOff; end
      CMD_BACK:   begin w.l = DirRev; w.r = DirRev; end
      CMD_SPIN_L: begin w.l = DirRev; w.r = DirFwd; end
      CMD_SPIN_R: begin w.l = DirFwd; w.r = DirRev; end
      default:    ;
    endcase
    return w;
  endfunction

  // Off is compatible with either direction; only + <-> - counts as a flip.
  function automatic logic is_flip(input dir_e cur, input dir_e nxt);
    return ((cur == DirFwd) && (nxt == DirRev)) || ((cur == DirRev) && (nxt == DirFwd));
  endfunction

endpackage

// File: rtl/motor_pwm.sv
// Free-running PWM counter with a soft-start duty ramp that steps at each period wrap.
module motor_pwm #(
  parameter int unsigned PWM_PERIOD = 200,
  parameter int unsigned DUTY_STEP  = 10,
  parameter int unsigned DW         = 8
) (
  input  logic          clk2,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          active,
  output logic          pwm,
  output logic          wrap,
  output logic [DW-1:0] duty
);

  localparam logic [DW-1:0] Last   = DW'(PWM_PERIOD - 1);
  localparam logic [DW:0]   Period = (DW + 1)'(PWM_PERIOD);
  localparam logic [DW:0]   Step   = (DW + 1)'(DUTY_STEP);

  logic [DW-1:0] cnt_q;
  logic [DW-1:0] duty_q;
  logic [DW:0]   duty_sum;

  assign wrap     = (cnt_q == Last);
  assign pwm      = (cnt_q < duty_q);
  assign duty     = duty_q;
  assign duty_sum = {1'b0, duty_q} + Step;

  always_ff @(posedge clk2) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      duty_q <= '0;
    end else begin
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      if (clr) begin
        duty_q <= '0;
      end else if (active && wrap) begin
        duty_q <= (duty_sum > Period) ? Period[DW-1:0] : duty_sum[DW-1:0];
      end
    end
  end

endmodule

// File: rtl/drive_arbiter.sv
// Fixed-priority arbitration of three motion requesters onto one two-wheel motor driver,
// with soft-start PWM and a dead interval whenever a wheel reverses.
module drive_arbiter
  import drive_arbiter_pkg::*;
#(
  parameter int unsigned PWM_PERIOD = 200,
  parameter int unsigned DUTY_STEP  = 10,
  parameter int unsigned DEAD_CYC   = 1000,
  parameter int unsigned DW         = 8
) (
  input  logic          clk2,
  input  logic          rst_n,
  input  logic          enc,
  input  logic          obs_vld,
  input  logic [2:0]    obs_cmd,
  input  logic          rmt_vld,
  input  logic [2:0]    rmt_cmd,
  input  logic          line_vld,
  input  logic [2:0]    line_cmd,
  output logic [2:0]    gnt,
  output logic          zuo1,
  output logic          zuo2,
  output logic          you1,
  output logic          you2,
  output logic          en1,
  output logic          en2,
  output logic [1:0]    state,
  output logic [DW-1:0] duty
);

  localparam int unsigned DeadW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

  logic [2:0]       gnt_q, gnt_d;
  logic [2:0]       cmd_q, cmd_d;
  state_e           state_q;
  dir_e             wl_q, wr_q;
  logic [DeadW-1:0] dead_q;
  wheels_t          cmd_w;
  logic             cmd_stop, flip, stay_drive, pwm, wrap;

  always_comb begin
    gnt_d = 3'b000;
    cmd_d = CMD_STOP;
    if (obs_vld) begin
      gnt_d = 3'b100;
      cmd_d = obs_cmd;
    end else if (rmt_vld) begin
      gnt_d = 3'b010;
      cmd_d = rmt_cmd;
    end else if (line_vld) begin
      gnt_d = 3'b001;
      cmd_d = line_cmd;
    end
    if (cmd_d == 3'd7) cmd_d = CMD_STOP;
  end

  assign cmd_w      = cmd_wheels(cmd_q);
  assign cmd_stop   = (cmd_q == CMD_STOP);
  assign flip       = is_flip(wl_q, cmd_w.l) || is_flip(wr_q, cmd_w.r);
  // Duty survives only while DRIVE continues into DRIVE; every other path restarts the ramp.
  assign stay_drive = !enc && (state_q == StDrive) && !cmd_stop && !flip;

  motor_pwm #(
    .PWM_PERIOD(PWM_PERIOD),
    .DUTY_STEP (DUTY_STEP),
    .DW        (DW)
  ) u_pwm (
    .clk2  (clk2),
    .rst_n (rst_n),
    .clr   (!stay_drive),
    .active(stay_drive),
    .pwm   (pwm),
    .wrap  (wrap),
    .duty  (duty)
  );

  always_ff @(posedge clk2) begin
    if (!rst_n) begin
      gnt_q   <= 3'b000;
      cmd_q   <= CMD_STOP;
      state_q <= StIdle;
      wl_q    <= DirOff;
      wr_q    <= DirOff;
      dead_q  <= '0;
    end else begin
      gnt_q <= gnt_d;
      cmd_q <= cmd_d;
      if (enc) begin
        state_q <= StIdle;
        wl_q    <= DirOff;
        wr_q    <= DirOff;
        dead_q  <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (!cmd_stop) begin
              state_q <= StDrive;
              wl_q    <= cmd_w.l;
              wr_q    <= cmd_w.r;
            end
          end
          StDrive: begin
            if (cmd_stop) begin
              state_q <= StIdle;
              wl_q    <= DirOff;
              wr_q    <= DirOff;
            end else if (flip) begin
              state_q <= StDead;
              wl_q    <= DirOff;
              wr_q    <= DirOff;
              dead_q  <= DeadW'(DEAD_CYC - 1);
            end else begin
              wl_q <= cmd_w.l;
              wr_q <= cmd_w.r;
            end
          end
          StDead: begin
            if (dead_q == '0) begin
              if (!cmd_stop) begin
                state_q <= StDrive;
                wl_q    <= cmd_w.l;
                wr_q    <= cmd_w.r;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              dead_q <= dead_q - 1'b1;
            end
          end
          default: begin
            state_q <= StIdle;
            wl_q    <= DirOff;
            wr_q    <= DirOff;
          end
        endcase
      end
    end
  end

  assign gnt   = gnt_q;
  assign state = state_q;
  assign zuo1  = (wl_q == DirFwd);
  assign zuo2  = (wl_q == DirRev);
  assign you1  = (wr_q == DirFwd);
  assign you2  = (wr_q == DirRev);
  assign en1   = (wl_q != DirOff) && pwm;
  assign en2   = (wr_q != DirOff) && pwm;

endmodule

// File: tb/tb_drive_arbiter.sv
// Directed bench for drive_arbiter with PWM_PERIOD=10, DUTY_STEP=5, DEAD_CYC=4.
module tb_drive_arbiter;

  logic       clk2 = 1'b0;
  logic       rst_n, enc;
  logic       obs_vld, rmt_vld, line_vld;
  logic [2:0] obs_cmd, rmt_cmd, line_cmd;
  logic [2:0] gnt;
  logic       zuo1, zuo2, you1, you2, en1, en2;
  logic [1:0] state;
  logic [7:0] duty;

  int total = 0;
  int bad   = 0;
  int hi;

  always #5 clk2 = ~clk2;

  drive_arbiter #(
    .PWM_PERIOD(10),
    .DUTY_STEP (5),
    .DEAD_CYC  (4),
    .DW        (8)
  ) dut (
    .clk2    (clk2),
    .rst_n   (rst_n),
    .enc     (enc),
    .obs_vld (obs_vld),
    .obs_cmd (obs_cmd),
    .rmt_vld (rmt_vld),
    .rmt_cmd (rmt_cmd),
    .line_vld(line_vld),
    .line_cmd(line_cmd),
    .gnt     (gnt),
    .zuo1    (zuo1),
    .zuo2    (zuo2),
    .you1    (you1),
    .you2    (you2),
    .en1     (en1),
    .en2     (en2),
    .state   (state),
    .duty    (duty)
  );

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Leaves the DUT just out of reset with PWM counter at 0 and all requesters idle.
  task automatic do_reset();
    rst_n = 1'b0; enc = 1'b0;
    obs_vld = 1'b0; rmt_vld = 1'b0; line_vld = 1'b0;
    obs_cmd = 3'd0; rmt_cmd = 3'd0; line_cmd = 3'd0;
    ticks(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0; obs_vld = 1'b1; obs_cmd = 3'd1; line_vld = 1'b1; line_cmd = 3'd1;
    ticks(2);
    total++;
    if ({gnt, zuo1, zuo2, you1, you2, en1, en2, state, duty} !== 19'd0) begin
      bad++;
      $display("FAIL reset_outputs: got gnt=%b pins=%b state=%b duty=%0d want all 0",
               gnt, {zuo1, zuo2, you1, you2, en1, en2}, state, duty);
    end
  endtask

  task automatic test_fwd_ramp();
    do_reset();
    line_vld = 1'b1; line_cmd = 3'd1;
    tick();
    total++;
    if ({gnt, zuo1} !== 4'b0010) begin
      bad++; $display("FAIL fwd_gnt_edge1: got gnt=%b zuo1=%b want 001/0", gnt, zuo1);
    end
    tick();
    total++;
    if ({zuo1, zuo2, you1, you2, state, duty} !== {4'b1010, 2'b01, 8'd0}) begin
      bad++;
      $display("FAIL fwd_pins_edge2: got pins=%b state=%b duty=%0d want 1010/01/0",
               {zuo1, zuo2, you1, you2}, state, duty);
    end
    hi = 0;
    for (int i = 3; i <= 9; i++) begin
      tick();
      hi += int'(en1 | en2) + int'(duty != 8'd0);
    end
    total++;
    if (hi !== 0) begin
      bad++; $display("FAIL fwd_pre_wrap: got %0d active samples want 0", hi);
    end
    tick();
    total++;
    if (duty !== 8'd5) begin
      bad++; $display("FAIL fwd_duty_wrap1: got %0d want 5", duty);
    end
    hi = int'(en1 & en2);
    for (int i = 11; i <= 19; i++) begin
      tick();
      hi += int'(en1 & en2);
    end
    total++;
    if (hi !== 5) begin
      bad++; $display("FAIL fwd_en_half: got %0d high cycles want 5", hi);
    end
    tick();
    total++;
    if (duty !== 8'd10) begin
      bad++; $display("FAIL fwd_duty_wrap2: got %0d want 10", duty);
    end
    hi = int'(en1 & en2);
    for (int i = 21; i <= 29; i++) begin
      tick();
      hi += int'(en1 & en2);
    end
    total++;
    if (hi !== 10) begin
      bad++; $display("FAIL fwd_en_full: got %0d high cycles want 10", hi);
    end
  endtask

  task automatic test_reverse_dead();
    do_reset();
    line_vld = 1'b1; line_cmd = 3'd1;
    ticks(2);
    obs_vld = 1'b1; obs_cmd = 3'd4;
    tick();
    total++;
    if ({gnt, zuo1, you1} !== 5'b10011) begin
      bad++; $display("FAIL rev_gnt: got gnt=%b zuo1/you1=%b%b want 100/11", gnt, zuo1, you1);
    end
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (state == 2'b10 && {zuo1, zuo2, you1, you2, en1, en2} == 6'd0 && duty == 8'd0) hi++;
    end
    total++;
    if (hi !== 4) begin
      bad++; $display("FAIL rev_dead_len: got %0d dead cycles want 4", hi);
    end
    tick();
    total++;
    if ({zuo1, zuo2, you1, you2, state, duty} !== {4'b0101, 2'b01, 8'd0}) begin
      bad++;
      $display("FAIL rev_back_pins: got pins=%b state=%b duty=%0d want 0101/01/0",
               {zuo1, zuo2, you1, you2}, state, duty);
    end
    ticks(2);
    total++;
    if (duty !== 8'd5) begin
      bad++; $display("FAIL rev_ramp_restart: got %0d want 5", duty);
    end
  endtask

  task automatic test_compatible_turn();
    do_reset();
    line_vld = 1'b1; line_cmd = 3'd1;
    ticks(10);
    rmt_vld = 1'b1; rmt_cmd = 3'd2;
    tick();
    total++;
    if ({gnt, zuo1} !== 4'b0101) begin
      bad++; $display("FAIL turn_gnt: got gnt=%b zuo1=%b want 010/1", gnt, zuo1);
    end
    tick();
    total++;
    if ({zuo1, zuo2, you1, you2, en1, en2, state, duty} !== {6'b001001, 2'b01, 8'd5}) begin
      bad++;
      $display("FAIL turn_left: got pins=%b state=%b duty=%0d want 001001/01/5",
               {zuo1, zuo2, you1, you2, en1, en2}, state, duty);
    end
  endtask

  task automatic test_inhibit();
    do_reset();
    line_vld = 1'b1; line_cmd = 3'd1;
    ticks(20);
    total++;
    if (duty !== 8'd10) begin
      bad++; $display("FAIL enc_pre_duty: got %0d want 10", duty);
    end
    enc = 1'b1;
    tick();
    total++;
    if ({gnt, zuo1, zuo2, you1, you2, en1, en2, state, duty} !== {3'b001, 16'd0}) begin
      bad++;
      $display("FAIL enc_force_idle: got gnt=%b pins=%b state=%b duty=%0d want 001/0/00/0",
               gnt, {zuo1, zuo2, you1, you2, en1, en2}, state, duty);
    end
    ticks(2);
    enc = 1'b0;
    tick();
    total++;
    if ({zuo1, you1, state, duty} !== {2'b11, 2'b01, 8'd0}) begin
      bad++;
      $display("FAIL enc_release: got zuo1/you1=%b%b state=%b duty=%0d want 11/01/0",
               zuo1, you1, state, duty);
    end
    ticks(6);
    total++;
    if (duty !== 8'd5) begin
      bad++; $display("FAIL enc_ramp_restart: got %0d want 5", duty);
    end
  endtask

  task automatic test_dead_to_stop();
    do_reset();
    line_vld = 1'b1; line_cmd = 3'd5;
    ticks(2);
    total++;
    if ({zuo1, zuo2, you1, you2} !== 4'b0110) begin
      bad++; $display("FAIL spinl_pins: got %b want 0110", {zuo1, zuo2, you1, you2});
    end
    line_cmd = 3'd6;
    tick();
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) line_cmd = 3'd0;
      if (state == 2'b10 && {zuo1, zuo2, you1, you2, en1, en2} == 6'd0) hi++;
    end
    total++;
    if (hi !== 4) begin
      bad++; $display("FAIL spin_dead_len: got %0d dead cycles want 4", hi);
    end
    tick();
    total++;
    if ({zuo1, zuo2, you1, you2, en1, en2, state} !== 8'd0) begin
      bad++;
      $display("FAIL spin_dead_idle: got pins=%b state=%b want 0/00",
               {zuo1, zuo2, you1, you2, en1, en2}, state);
    end
  endtask

  task automatic test_reset_in_dead();
    do_reset();
    line_vld = 1'b1; line_cmd = 3'd5;
    ticks(2);
    line_cmd = 3'd6;
    ticks(3);
    total++;
    if (state !== 2'b10) begin
      bad++; $display("FAIL rst_dead_enter: got state=%b want 10", state);
    end
    rst_n = 1'b0;
    tick();
    total++;
    if ({gnt, zuo1, zuo2, you1, you2, en1, en2, state, duty} !== 19'd0) begin
      bad++;
      $display("FAIL rst_mid_dead: got gnt=%b pins=%b state=%b duty=%0d want all 0",
               gnt, {zuo1, zuo2, you1, you2, en1, en2}, state, duty);
    end
    rst_n = 1'b1;
    ticks(2);
    total++;
    if ({gnt, zuo1, zuo2, you1, you2, state} !== {3'b001, 4'b1001, 2'b01}) begin
      bad++;
      $display("FAIL rst_no_dead_owed: got gnt=%b pins=%b state=%b want 001/1001/01",
               gnt, {zuo1, zuo2, you1, you2}, state);
    end
  endtask

  task automatic test_priority();
    do_reset();
    obs_vld = 1'b1; obs_cmd = 3'd1;
    rmt_vld = 1'b1; rmt_cmd = 3'd2;
    line_vld = 1'b1; line_cmd = 3'd3;
    tick();
    total++;
    if (gnt !== 3'b100) begin
      bad++; $display("FAIL prio_obs: got %b want 100", gnt);
    end
    obs_vld = 1'b0;
    tick();
    total++;
    if (gnt !== 3'b010) begin
      bad++; $display("FAIL prio_rmt: got %b want 010", gnt);
    end
    rmt_vld = 1'b0;
    tick();
    total++;
    if (gnt !== 3'b001) begin
      bad++; $display("FAIL prio_line: got %b want 001", gnt);
    end
    line_vld = 1'b0;
    tick();
    total++;
    if (gnt !== 3'b000) begin
      bad++; $display("FAIL prio_none: got %b want 000", gnt);
    end
    ticks(2);
    line_vld = 1'b1; line_cmd = 3'd7;
    ticks(3);
    total++;
    if ({gnt, state, zuo1, you1} !== {3'b001, 2'b00, 2'b00}) begin
      bad++;
      $display("FAIL code7_stop: got gnt=%b state=%b zuo1/you1=%b%b want 001/00/00",
               gnt, state, zuo1, you1);
    end
  endtask

  initial begin
    test_reset();
    test_fwd_ramp();
    test_reverse_dead();
    test_compatible_turn();
    test_inhibit();
    test_dead_to_stop();
    test_reset_in_dead();
    test_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
